// File: rtl/sobel_edge_detector.sv
// Streaming 3x3 Sobel edge detector: |Gx|+|Gy| per interior pixel of a raster-order 8-bit frame.
// Latency: output valid on the 2nd rising edge after the edge that accepts the window-completing pixel.
// Backpressure: none; the source paces input with pixel_valid, the sink must take every pixel_out_valid.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      frame start request, sampled in IDLE/DONE
//   pixel_in, pixel_valid      input pixel stream, one pixel per valid cycle
//   pixel_out, pixel_out_valid saturated edge magnitude and its 1-cycle qualifier
//   done                       1-cycle pulse the cycle after the final output of a frame
module sobel_edge_detector #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] pixel_in,
    input  logic       pixel_valid,
    output logic [7:0] pixel_out,
    output logic       pixel_out_valid,
    output logic       done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          last_pix;
    logic          drain_end;
    logic          done_nxt;

    // Line buffers: lb0 holds row r-1, lb1 holds row r-2 at the current column.
    logic [7:0]    lb0 [IMG_WIDTH];
    logic [7:0]    lb1 [IMG_WIDTH];
    // 3x3 window, w[row][col], row 0 = top, col 0 = left.
    logic [7:0]    w [3][3];
    logic          win_vld;

    // Gradients are carried as 11-bit two's complement.
    logic [10:0]   gx_c, gy_c, gx_q, gy_q;
    logic          s1_vld;
    logic [10:0]   abs_x, abs_y, mag;
    logic [7:0]    sat;

    function automatic logic [10:0] ext1(input logic [7:0] p);
        return {3'b000, p};
    endfunction

    function automatic logic [10:0] ext2(input logic [7:0] p);
        return {2'b00, p, 1'b0};
    endfunction

    assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);
    // Pipeline is empty once the last output is on the port and nothing is behind it.
    assign drain_end = pixel_out_valid && !s1_vld && !win_vld;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
            S_RUN:          if (pixel_valid && last_pix) state_nxt = S_FLUSH;
            S_FLUSH:        if (drain_end) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        accept   = 1'b0;
        done_nxt = 1'b0;
        case (state)
            S_IDLE, S_DONE: accept = start && pixel_valid;
            S_RUN:          accept = pixel_valid;
            S_FLUSH:        done_nxt = drain_end;
            default:        accept = 1'b0;
        endcase
    end

    // Counters return to (0,0) on the last pixel, so IDLE/DONE always start a frame cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row     <= '0;
            col     <= '0;
            win_vld <= 1'b0;
        end else begin
            win_vld <= accept && (row >= RW'(2)) && (col >= CW'(2));
            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Storage only; contents are don't-care after reset. Stale columns from the
    // previous row sit in the window at c<2 but never produce an output.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                w[i][0] <= w[i][1];
                w[i][1] <= w[i][2];
            end
            w[0][2]  <= lb1[col];
            w[1][2]  <= lb0[col];
            w[2][2]  <= pixel_in;
            lb1[col] <= lb0[col];
            lb0[col] <= pixel_in;
        end
    end

    always_comb begin
        gx_c = (ext1(w[0][2]) + ext2(w[1][2]) + ext1(w[2][2]))
             - (ext1(w[0][0]) + ext2(w[1][0]) + ext1(w[2][0]));
        gy_c = (ext1(w[2][0]) + ext2(w[2][1]) + ext1(w[2][2]))
             - (ext1(w[0][0]) + ext2(w[0][1]) + ext1(w[0][2]));
    end

    // Stage 1: gradients.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            gx_q   <= '0;
            gy_q   <= '0;
        end else begin
            s1_vld <= win_vld;
            if (win_vld) begin
                gx_q <= gx_c;
                gy_q <= gy_c;
            end
        end
    end

    always_comb begin
        abs_x = gx_q[10] ? (~gx_q + 11'd1) : gx_q;
        abs_y = gy_q[10] ? (~gy_q + 11'd1) : gy_q;
        mag   = abs_x + abs_y;
        sat   = (mag > 11'd255) ? 8'hFF : mag[7:0];
    end

    // Stage 2: magnitude and saturation; pixel_out holds between valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out       <= '0;
            pixel_out_valid <= 1'b0;
            done            <= 1'b0;
        end else begin
            pixel_out_valid <= s1_vld;
            done            <= done_nxt;
            if (s1_vld) pixel_out <= sat;
        end
    end

endmodule

// File: tb/tb_sobel_edge_detector.sv
module tb_sobel_edge_detector;

    localparam int W = 8;
    localparam int H = 8;
    localparam int NOUT = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] pixel_in;
    logic       pixel_valid;
    logic [7:0] pixel_out;
    logic       pixel_out_valid;
    logic       done;

    sobel_edge_detector #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .pixel_in        (pixel_in),
        .pixel_valid     (pixel_valid),
        .pixel_out       (pixel_out),
        .pixel_out_valid (pixel_out_valid),
        .done            (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int img[H][W];
    int out_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_out_cyc = 0;
    int first_out_cyc = -1;
    int acc22_cyc = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference Sobel for the window whose top-left pixel is (r,c).
    function automatic int sobel_ref(input int r, input int c);
        int gx, gy, m;
        gx = (img[r][c+2] + 2*img[r+1][c+2] + img[r+2][c+2])
           - (img[r][c]   + 2*img[r+1][c]   + img[r+2][c]);
        gy = (img[r+2][c] + 2*img[r+2][c+1] + img[r+2][c+2])
           - (img[r][c]   + 2*img[r][c+1]   + img[r][c+2]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    // Output monitor / scoreboard consumer, sampling away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pixel_out_valid) begin
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                out_cnt++;
                if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
                else check("pixel_out", int'(pixel_out), exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic set_image(input int mode);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (mode)
                    0:       img[r][c] = 100;
                    1:       img[r][c] = 10 * c;
                    2:       img[r][c] = (r < 4) ? 0 : 200;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
        if (mode == 3) begin
            img[0][0] = 10; img[0][1] = 20; img[0][2] = 30;
            img[1][0] = 15; img[1][1] = 25; img[1][2] = 35;
            img[2][0] = 20; img[2][1] = 30; img[2][2] = 200;
        end
    endtask

    // Drive the first npix pixels of the frame; start accompanies pixel (0,0).
    task automatic drive_frame(input bit gaps, input int npix);
        int n;
        n = 0;
        first_out_cyc = -1;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (n >= npix) return;
                if (gaps) begin
                    while ($urandom_range(0, 2) == 0) begin
                        @(negedge clk);
                        start = 1'b0;
                        pixel_valid = 1'b0;
                    end
                end
                @(negedge clk);
                start = (r == 0 && c == 0);
                pixel_valid = 1'b1;
                pixel_in = 8'(img[r][c]);
                if (r == 2 && c == 2) acc22_cyc = cyc + 1;
                if (r >= 2 && c >= 2) exp_q.push_back(sobel_ref(r - 2, c - 2));
                n++;
            end
        end
    endtask

    // Let the frame drain while offering extra pixels that must be ignored.
    task automatic finish_frame(input string tag, input int out_base, input int done_base);
        repeat (12) begin
            @(negedge clk);
            start = 1'b0;
            pixel_valid = 1'b1;
            pixel_in = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        pixel_valid = 1'b0;
        check({tag, "_out_count"}, out_cnt - out_base, NOUT);
        check({tag, "_done_pulses"}, done_cnt - done_base, 1);
        check({tag, "_done_after_last"}, done_cyc, last_out_cyc + 1);
        check({tag, "_first_latency"}, first_out_cyc - acc22_cyc, 2);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic run_frame(input string tag, input int mode, input bit gaps);
        int ob, db;
        set_image(mode);
        ob = out_cnt;
        db = done_cnt;
        drive_frame(gaps, W * H);
        finish_frame(tag, ob, db);
    endtask

    initial begin
        int ob, db;
        rst_n = 1'b0;
        start = 1'b0;
        pixel_valid = 1'b0;
        pixel_in = '0;

        // Reset held 5 cycles, then pixels offered without start.
        repeat (5) @(negedge clk);
        check("rst_pixel_out", int'(pixel_out), 0);
        check("rst_valid", int'(pixel_out_valid), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            pixel_valid = 1'b1;
            pixel_in = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        pixel_valid = 1'b0;
        check("idle_no_output", out_cnt, 0);
        check("idle_no_done", done_cnt, 0);
        check("idle_pixel_out", int'(pixel_out), 0);

        run_frame("const", 0, 1'b0);
        run_frame("hramp", 1, 1'b0);
        run_frame("vstep", 2, 1'b0);
        run_frame("corner", 3, 1'b0);
        run_frame("gapped", 4, 1'b1);

        // Mid-frame reset: abort immediately, no done, no residual outputs.
        set_image(4);
        drive_frame(1'b1, 30);
        @(negedge clk);
        pixel_valid = 1'b0;
        #2 rst_n = 1'b0;
        exp_q.delete();
        ob = out_cnt;
        db = done_cnt;
        #1;
        check("midrst_valid", int'(pixel_out_valid), 0);
        check("midrst_pixel_out", int'(pixel_out), 0);
        check("midrst_done", int'(done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            pixel_valid = 1'b1;
            pixel_in = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        pixel_valid = 1'b0;
        check("midrst_no_output", out_cnt - ob, 0);
        check("midrst_no_done", done_cnt - db, 0);

        run_frame("recover", 4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
